// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream instruction loader that packs bytes MSB-first into 32-bit memory writes
module instr_loader #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [5:0]  num_words_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  word_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic [6:0]  len_q;
  logic [5:0]  cnt_q;

  logic [6:0]  eff_len;
  logic [6:0]  cnt_inc;
  logic        accept;
  logic        start_ok;

  // Zero or an oversize request both mean "fill the whole memory".
  always_comb begin
    eff_len = {1'b0, num_words_i};
    if (num_words_i == 6'd0 || int'(num_words_i) > DEPTH) begin
      eff_len = 7'(DEPTH);
    end
  end

  assign cnt_inc  = {1'b0, cnt_q} + 7'd1;
  assign accept   = (state_q == LOAD) && byte_valid_i && !abort_i;
  assign start_ok = start_i && !abort_i && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = LOAD;
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept && idx_q == 2'd3) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_inc == len_q) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Abort drops the partial word but keeps the count of words already written.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
      len_q  <= 7'd0;
      cnt_q  <= 6'd0;
    end else if (abort_i) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
    end else if (start_ok) begin
      word_q <= 32'd0;
      idx_q  <= 2'd0;
      len_q  <= eff_len;
      cnt_q  <= 6'd0;
    end else if (accept) begin
      unique case (idx_q)
        2'd0: word_q[31:24] <= byte_i;
        2'd1: word_q[23:16] <= byte_i;
        2'd2: word_q[15:8]  <= byte_i;
        2'd3: word_q[7:0]   <= byte_i;
        default: word_q <= word_q;
      endcase
      idx_q <= idx_q + 2'd1;
    end else if (state_q == WRITE) begin
      cnt_q <= cnt_inc[5:0];
      idx_q <= 2'd0;
    end
  end

  // Address and data are zeroed outside the write strobe so the bus never shows an out-of-range address.
  always_comb begin
    byte_ready_o = (state_q == LOAD);
    wr_en_o      = (state_q == WRITE) && !abort_i;
    wr_addr_o    = 32'd0;
    wr_data_o    = 32'd0;
    if (wr_en_o) begin
      wr_addr_o = {24'd0, cnt_q, 2'b00};
      wr_data_o = word_q;
    end
    busy_o     = (state_q == LOAD) || (state_q == WRITE);
    done_o     = (state_q == DONE);
    word_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed/random bench for instr_loader with a word-packing reference model
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  num = 6'd0;
  logic [7:0]  byt = 8'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [5:0]  cnt;

  instr_loader #(.DEPTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .num_words_i  (num),
    .byte_i       (byt),
    .byte_valid_i (valid),
    .byte_ready_o (ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .word_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          hs_cyc[$];
  logic [7:0]  bq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      w_addr.push_back(wr_addr);
      w_data.push_back(wr_data);
      w_cyc.push_back(cyc);
    end
    if (valid && ready) hs_cyc.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    hs_cyc.delete();
  endtask

  task automatic do_start(input logic [5:0] n);
    start = 1'b1;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  // Leaves valid high with the accepted byte; callers must change or drop it before the next edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (g > 0) begin
      valid = 1'b0;
      repeat (g) tick();
    end
    valid = 1'b1;
    byt   = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ready) break;
      if (t == 50) begin
        check("hs_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: word k is bytes 4k..4k+3 MSB-first, written to byte address 4k.
  task automatic check_writes(input string tag, input int nwords);
    check({tag, "_nwr"}, 32'(w_addr.size()), 32'(nwords));
    for (int k = 0; k < nwords && k < w_addr.size(); k++) begin
      check({tag, "_addr"}, w_addr[k], 32'(4 * k));
      check({tag, "_data"}, w_data[k], {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]});
    end
  endtask

  initial begin
    logic [5:0] n;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", wr_addr, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    num   = 6'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("prio_busy", 32'(busy), 32'd0);
    check("prio_ready", 32'(ready), 32'd0);

    // Basic two-word load
    clear_q();
    bq = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
    do_start(6'd2);
    for (int i = 0; i < 8; i++) send_byte(bq[i], 0);
    valid = 1'b0;
    repeat (3) tick();
    check_writes("basic", 2);
    if (w_cyc.size() >= 2) check("basic_gap", 32'(w_cyc[1] - w_cyc[0]), 32'd5);
    @(negedge clk);
    check("basic_done", 32'(done), 32'd1);
    check("basic_cnt", 32'(cnt), 32'd2);
    check("basic_busy", 32'(busy), 32'd0);

    // Three-word load with random gaps and a start pulse during LOAD
    clear_q();
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    do_start(6'd3);
    for (int i = 0; i < 12; i++) begin
      send_byte(bq[i], 3);
      if (i == 5) begin
        valid = 1'b0;
        num   = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    valid = 1'b0;
    repeat (3) tick();
    check_writes("stall", 3);
    for (int k = 0; k < 3 && k < w_cyc.size() && 4 * k + 3 < hs_cyc.size(); k++)
      check("stall_lat", 32'(w_cyc[k] - hs_cyc[4*k+3]), 32'd1);
    @(negedge clk);
    check("stall_done", 32'(done), 32'd1);
    check("stall_cnt", 32'(cnt), 32'd3);

    // Full depth: zero length, then an oversize length
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 6'd0 : 6'($urandom_range(33, 63));
      clear_q();
      bq.delete();
      for (int i = 0; i < 128; i++) bq.push_back(8'($urandom));
      do_start(n);
      for (int i = 0; i < 128; i++) send_byte(bq[i], (r == 1) ? 1 : 0);
      byt = 8'hAA;
      repeat (2) tick();
      @(negedge clk);
      check("full_ready129", 32'(ready), 32'd0);
      check("full_done", 32'(done), 32'd1);
      check("full_cnt", 32'(cnt), 32'd32);
      check("full_hs", 32'(hs_cyc.size()), 32'd128);
      valid = 1'b0;
      tick();
      check_writes("full", 32);
    end

    // Abort with the 3rd byte of word 1 in a 4-word session
    clear_q();
    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
    do_start(6'd4);
    for (int i = 0; i < 6; i++) send_byte(bq[i], 0);
    byt   = bq[6];
    abort = 1'b1;
    @(negedge clk);
    check("abort_ready_before", 32'(ready), 32'd1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(cnt), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    repeat (8) tick();
    valid = 1'b0;
    check_writes("abort", 1);

    // Abort arriving with the 4th byte suppresses the write
    clear_q();
    do_start(6'd4);
    for (int i = 0; i < 3; i++) send_byte(bq[i], 0);
    byt   = bq[3];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    valid = 1'b0;
    repeat (3) tick();
    check("abort4_nwr", 32'(w_addr.size()), 32'd0);
    check("abort4_cnt", 32'(cnt), 32'd0);
    check("abort4_busy", 32'(busy), 32'd0);

    // Reset during WRITE
    clear_q();
    do_start(6'd2);
    for (int i = 0; i < 4; i++) send_byte(bq[i], 0);
    valid = 1'b0;
    check("rstw_wr_en_pre", 32'(wr_en), 32'd1);
    rst = 1'b0;
    #1;
    check("rstw_wr_en", 32'(wr_en), 32'd0);
    check("rstw_addr", wr_addr, 32'd0);
    check("rstw_data", wr_data, 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_cnt", 32'(cnt), 32'd0);
    check("rstw_nwr", 32'(w_addr.size()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) tick();
    check("rstw_idle", 32'(busy), 32'd0);
    clear_q();
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
    do_start(6'd1);
    for (int i = 0; i < 4; i++) send_byte(bq[i], 1);
    valid = 1'b0;
    repeat (3) tick();
    check_writes("rstw_reload", 1);
    @(negedge clk);
    check("rstw_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
